// File: rtl/cassette_saver.sv
// cassette_saver
// Serialises a RAM region as an Oric .TAP byte stream:
//   SYNC_COUNT x 0x16, 0x24, 9-byte header, null-terminated name, data bytes.
// Sits between the machine RAM read port and the ioctl upload buffer.
//
// Ports
//   clk, reset            system clock, asynchronous active-high reset
//   start, abort          single-cycle requests (start sampled only in IDLE)
//   start_addr, end_addr  inclusive RAM range to save
//   file_type, autorun    header type / autorun bytes
//   name                  filename, char i in bits [8i+7:8i]
//   ram_addr, ram_rd      RAM read port (data returns on ram_q one clk later)
//   out_data/valid/ready  byte stream handshake, out_last on final data byte
//   busy, done, error     status: busy while saving, done/error one-cycle pulses
//
// Optional build macro CASSETTE_SAVER_BYTECOUNT_EN adds output byte_count,
// the number of accepted stream bytes since the last accepted start.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start
// SYNC  | emitting 0x16 sync bytes
// MARK  | emitting 0x24 marker
// HDR   | emitting 9 header bytes
// NAME  | emitting filename chars up to first 0x00 or NAME_MAX
// NUL   | emitting name terminator 0x00
// FETCH | ram_rd asserted for current address
// WAIT  | capturing ram_q into the data register
// DATA  | presenting the data byte
// DONE  | one-cycle done pulse

module cassette_saver #(
    parameter int SYNC_COUNT = 4,
    parameter int NAME_MAX   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [15:0]           start_addr,
    input  logic [15:0]           end_addr,
    input  logic [7:0]            file_type,
    input  logic [7:0]            autorun,
    input  logic [8*NAME_MAX-1:0] name,
    output logic [15:0]           ram_addr,
    output logic                  ram_rd,
    input  logic [7:0]            ram_q,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  error
`ifdef CASSETTE_SAVER_BYTECOUNT_EN
    ,
    output logic [16:0]           byte_count
`endif
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_SYNC  = 4'd1;
    localparam logic [3:0] S_MARK  = 4'd2;
    localparam logic [3:0] S_HDR   = 4'd3;
    localparam logic [3:0] S_NAME  = 4'd4;
    localparam logic [3:0] S_NUL   = 4'd5;
    localparam logic [3:0] S_FETCH = 4'd6;
    localparam logic [3:0] S_WAIT  = 4'd7;
    localparam logic [3:0] S_DATA  = 4'd8;
    localparam logic [3:0] S_DONE  = 4'd9;

    localparam int         IW        = $clog2(NAME_MAX + 1);
    localparam logic [3:0] SYNC_LAST = 4'(SYNC_COUNT - 1);

    logic [3:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [16:0]           addr_q, addr_d;
    logic [15:0]           end_q, end_d;
    logic [15:0]           start_q, start_d;
    logic [7:0]            type_q, type_d;
    logic [7:0]            auto_q, auto_d;
    logic [8*NAME_MAX-1:0] name_q, name_d;
    logic [7:0]            data_q, data_d;
    logic                  error_q, error_d;

    // One extra always-zero slot so the look-ahead at idx+1 is always in
    // range and a full-length name terminates naturally.
    logic [7:0]            name_arr [NAME_MAX+1];
    logic [IW-1:0]         idx_nxt;
    logic [7:0]            hdr_byte;
    logic                  hs;
    logic                  start_ok;
    logic                  at_end;

    always_comb begin
        for (int i = 0; i < NAME_MAX; i++) begin
            name_arr[i] = name_q[8*i +: 8];
        end
        name_arr[NAME_MAX] = 8'h00;
    end

    assign idx_nxt  = idx_q + IW'(1);
    assign hs       = out_valid & out_ready;
    assign start_ok = (state_q == S_IDLE) && start && (end_addr >= start_addr);
    assign at_end   = (addr_q == {1'b0, end_q});

    always_comb begin
        hdr_byte = 8'h00;
        case (cnt_q)
            4'd2:    hdr_byte = type_q;
            4'd3:    hdr_byte = auto_q;
            4'd4:    hdr_byte = end_q[15:8];
            4'd5:    hdr_byte = end_q[7:0];
            4'd6:    hdr_byte = start_q[15:8];
            4'd7:    hdr_byte = start_q[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        end_d   = end_q;
        start_d = start_q;
        type_d  = type_q;
        auto_d  = auto_q;
        name_d  = name_q;
        data_d  = data_q;
        error_d = 1'b0;

        // abort wins over any handshake in the same cycle
        if (state_q != S_IDLE && abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (end_addr >= start_addr) begin
                            start_d = start_addr;
                            end_d   = end_addr;
                            type_d  = file_type;
                            auto_d  = autorun;
                            name_d  = name;
                            addr_d  = {1'b0, start_addr};
                            cnt_d   = 4'd0;
                            state_d = S_SYNC;
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                end
                S_SYNC: begin
                    if (hs) begin
                        if (cnt_q == SYNC_LAST) begin
                            state_d = S_MARK;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
                S_MARK: begin
                    if (hs) begin
                        cnt_d   = 4'd0;
                        state_d = S_HDR;
                    end
                end
                S_HDR: begin
                    if (hs) begin
                        if (cnt_q == 4'd8) begin
                            idx_d   = '0;
                            state_d = (name_arr[0] == 8'h00) ? S_NUL : S_NAME;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
                S_NAME: begin
                    if (hs) begin
                        if (name_arr[idx_nxt] == 8'h00) begin
                            state_d = S_NUL;
                        end else begin
                            idx_d = idx_nxt;
                        end
                    end
                end
                S_NUL: begin
                    if (hs) begin
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: state_d = S_WAIT;
                S_WAIT: begin
                    data_d  = ram_q;
                    state_d = S_DATA;
                end
                S_DATA: begin
                    if (hs) begin
                        if (at_end) begin
                            state_d = S_DONE;
                        end else begin
                            addr_d  = addr_q + 17'd1;
                            state_d = S_FETCH;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            end_q   <= '0;
            start_q <= '0;
            type_q  <= '0;
            auto_q  <= '0;
            name_q  <= '0;
            data_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            end_q   <= end_d;
            start_q <= start_d;
            type_q  <= type_d;
            auto_q  <= auto_d;
            name_q  <= name_d;
            data_q  <= data_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        out_data = 8'h00;
        case (state_q)
            S_SYNC:  out_data = 8'h16;
            S_MARK:  out_data = 8'h24;
            S_HDR:   out_data = hdr_byte;
            S_NAME:  out_data = name_arr[idx_q];
            S_NUL:   out_data = 8'h00;
            S_DATA:  out_data = data_q;
            default: out_data = 8'h00;
        endcase
    end

    assign out_valid = (state_q == S_SYNC) || (state_q == S_MARK) || (state_q == S_HDR) ||
                       (state_q == S_NAME) || (state_q == S_NUL)  || (state_q == S_DATA);
    assign out_last  = (state_q == S_DATA) && at_end;
    assign ram_addr  = addr_q[15:0];
    assign ram_rd    = (state_q == S_FETCH);
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign error     = error_q;

`ifdef CASSETTE_SAVER_BYTECOUNT_EN
    logic [16:0] byte_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_count_q <= '0;
        end else if (start_ok) begin
            byte_count_q <= '0;
        end else if (hs && !abort) begin
            byte_count_q <= byte_count_q + 17'd1;
        end
    end

    assign byte_count = byte_count_q;
`endif

endmodule
